// File: rtl/if_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared definitions for the instruction-fetch queue: default datapath width,
// default reset PC and the fetch FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package if_fetch_queue_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE    : no request outstanding, may issue (or hit in the icache)
    // WAIT    : one request outstanding, its word will be enqueued
    // DISCARD : one request outstanding, its word is stale after a redirect
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_queue_inst_fifo.sv
// ----------------------------------------------------------------------------
// if_inst_fifo
// Parametrised synchronous FIFO used to buffer {pc, instruction} pairs
// between the fetch logic and decode.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   flush      in   empty the FIFO; overrides push and pop in the same cycle
//   push       in   write push_data (accepted when not full, or full + pop)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  entry at the read pointer (meaningless when empty)
//   count      out  number of stored entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
// ----------------------------------------------------------------------------
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; the write and read pointers then both advance and count holds.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_C) || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);

endmodule

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch unit: owns the fetch PC, issues one word fetch at a time
// to mem_ctrl, buffers returned words in an if_inst_fifo and presents the
// queue head to decode over a valid/ready handshake. A branch redirect
// flushes the queue and, if a fetch is in flight, discards its data.
//
// Optional feature macro: IF_ICACHE_EN
//   Adds a direct-mapped word icache (ICACHE_LINES entries). A hit in IDLE
//   enqueues the word directly without a mem_ctrl request.
//
// Ports:
//   clk                    in   clock
//   rst                    in   synchronous active-high reset
//   branch_enable          in   redirect request, highest priority
//   branch_target          in   redirect PC
//   mem_ctrl_busy_in       in   mem_ctrl cannot accept a request
//   mem_ctrl_inst_done_in  in   one-cycle pulse, mem_ctrl_inst_in valid
//   mem_ctrl_inst_in       in   fetched instruction word
//   mem_ctrl_enable_out    out  fetch request strobe
//   mem_ctrl_addr_out      out  fetch address (0 when no request)
//   id_ready_in            in   decode accepts the head this cycle
//   if_valid_out           out  queue head valid
//   pc_out                 out  PC of queue head (0 when empty)
//   inst_out               out  instruction of queue head (0 when empty)
//   queue_full_out         out  queue holds QUEUE_DEPTH entries
// ----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter int              QUEUE_DEPTH  = 4,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEFAULT),
    parameter int              ICACHE_LINES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_enable,
    input  logic [XLEN-1:0] branch_target,
    input  logic            mem_ctrl_busy_in,
    input  logic            mem_ctrl_inst_done_in,
    input  logic [XLEN-1:0] mem_ctrl_inst_in,
    output logic            mem_ctrl_enable_out,
    output logic [XLEN-1:0] mem_ctrl_addr_out,
    input  logic            id_ready_in,
    output logic            if_valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    output logic            queue_full_out
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = 2 * XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            issue;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic [EW-1:0]   fifo_push_data;
    logic [EW-1:0]   fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

`ifdef IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             cache_valid_q [ICACHE_LINES];
    logic             cache_valid_d [ICACHE_LINES];
    logic [TAG_W-1:0] cache_tag_q   [ICACHE_LINES];
    logic [TAG_W-1:0] cache_tag_d   [ICACHE_LINES];
    logic [XLEN-1:0]  cache_data_q  [ICACHE_LINES];
    logic [XLEN-1:0]  cache_data_d  [ICACHE_LINES];
    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             cache_hit;

    assign lookup_idx = fetch_pc_q[IDX_W+1:2];
    assign lookup_tag = fetch_pc_q[XLEN-1:IDX_W+2];
    assign fill_idx   = req_pc_q[IDX_W+1:2];
    assign fill_tag   = req_pc_q[XLEN-1:IDX_W+2];
    assign cache_hit  = cache_valid_q[lookup_idx] &&
                        (cache_tag_q[lookup_idx] == lookup_tag);

    // Fills come only from a word that is really being enqueued for req_pc
    // (inst_done in WAIT); words returned in DISCARD never reach the cache.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if ((state_q == WAIT) && mem_ctrl_inst_done_in) begin
            cache_valid_d[fill_idx] = 1'b1;
            cache_tag_d[fill_idx]   = fill_tag;
            cache_data_d[fill_idx]  = mem_ctrl_inst_in;
        end
    end

    // Valid bits are cleared by reset so the cache starts cold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ICACHE_LINES; i++) begin
                cache_valid_q[i] <= 1'b0;
            end
        end else begin
            cache_valid_q <= cache_valid_d;
        end
    end

    // Tag and data arrays are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        cache_tag_q  <= cache_tag_d;
        cache_data_q <= cache_data_d;
    end
`endif

    // Next-state logic for the fetch FSM, fetch PC and queue control.
    // A branch overrides everything: the queue is flushed, no request is
    // issued and no push/pop happens. An outstanding request without a
    // simultaneous inst_done leaves us in DISCARD to swallow its word.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        issue          = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        fifo_push_data = {req_pc_q, mem_ctrl_inst_in};

        if (rst) begin
            state_d = IDLE;
        end else if (branch_enable) begin
            fifo_flush = 1'b1;
            fetch_pc_d = branch_target;
            if (((state_q == WAIT) || (state_q == DISCARD)) && !mem_ctrl_inst_done_in) begin
                state_d = DISCARD;
            end else begin
                state_d = IDLE;
            end
        end else begin
            fifo_pop = if_valid_out && id_ready_in;
            case (state_q)
                IDLE: begin
                    // A free slot is required before issuing so the returning
                    // word always has room, whatever decode does meanwhile.
                    if (!fifo_full) begin
`ifdef IF_ICACHE_EN
                        if (cache_hit) begin
                            fifo_push      = 1'b1;
                            fifo_push_data = {fetch_pc_q, cache_data_q[lookup_idx]};
                            fetch_pc_d     = fetch_pc_q + XLEN'(4);
                        end else if (!mem_ctrl_busy_in) begin
                            issue    = 1'b1;
                            req_pc_d = fetch_pc_q;
                            state_d  = WAIT;
                        end
`else
                        if (!mem_ctrl_busy_in) begin
                            issue    = 1'b1;
                            req_pc_d = fetch_pc_q;
                            state_d  = WAIT;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (mem_ctrl_inst_done_in) begin
                        fifo_push      = 1'b1;
                        fifo_push_data = {req_pc_q, mem_ctrl_inst_in};
                        fetch_pc_d     = req_pc_q + XLEN'(4);
                        state_d        = IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_ctrl_inst_done_in) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    if_inst_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign mem_ctrl_enable_out = issue;
    assign mem_ctrl_addr_out   = issue ? fetch_pc_q : '0;
    assign if_valid_out        = !fifo_empty;
    assign pc_out              = fifo_empty ? '0 : fifo_head[EW-1:XLEN];
    assign inst_out            = fifo_empty ? '0 : fifo_head[XLEN-1:0];
    assign queue_full_out      = fifo_full;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch unit for the RISC-V core; successor to the combinational IF stage.
- Owns the fetch PC and issues word fetches to the memory controller (mem_ctrl).
- Buffers returned instructions in a QUEUE_DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirects, including discarding a fetch still in flight when the redirect arrives.

Parameters:
- XLEN, 32: PC and instruction width.
- QUEUE_DEPTH, 4: instruction FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0: fetch PC after reset.
- ICACHE_LINES, 16: direct-mapped icache entries; power of two; used only with IF_ICACHE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- branch_enable  in  1  redirect request; wins over all other events
- branch_target  in  XLEN  redirect PC
- mem_ctrl_busy_in  in  1  mem_ctrl cannot accept a request this cycle
- mem_ctrl_inst_done_in  in  1  one-cycle pulse: mem_ctrl_inst_in is valid
- mem_ctrl_inst_in  in  XLEN  fetched instruction word
- mem_ctrl_enable_out  out  1  fetch request strobe
- mem_ctrl_addr_out  out  XLEN  fetch address
- id_ready_in  in  1  decode accepts this cycle
- if_valid_out  out  1  queue head valid
- pc_out  out  XLEN  PC of queue head
- inst_out  out  XLEN  instruction of queue head
- queue_full_out  out  1  count == QUEUE_DEPTH

Behaviour:
- All state is registered on posedge clk. Reset is synchronous and active-high.
- Reset values: fetch_pc = RESET_PC; FSM = IDLE; queue empty; all outputs 0.
- Output derivation: if_valid_out, pc_out and inst_out are driven from the registered queue head. When the queue is empty, pc_out and inst_out are 0.
- FSM state IDLE:
  - Issue when !mem_ctrl_busy_in and (count + 1) <= QUEUE_DEPTH; the +1 reserves a slot for the in-flight word.
  - On issue: mem_ctrl_enable_out = 1 for exactly one cycle, mem_ctrl_addr_out = fetch_pc, req_pc <= fetch_pc, go to WAIT.
- FSM state WAIT:
  - On inst_done: enqueue {req_pc, inst}, fetch_pc <= req_pc + 4, go to IDLE.
  - The next issue can occur in the following cycle, so the minimum issue-to-issue period is 2 cycles.
- FSM state DISCARD (entered when a branch arrives during WAIT):
  - On inst_done: drop the data, go to IDLE.
- Dequeue: the head pops when if_valid_out && id_ready_in. Push and pop may happen in the same cycle; count is unchanged and the FIFO stays correct even when full.
- Branch (branch_enable = 1), highest priority:
  - Queue cleared.
  - fetch_pc <= branch_target.
  - Any enqueue or pop that cycle is suppressed.
  - FSM goes to DISCARD if it was in WAIT and inst_done is not asserted that same cycle; otherwise it goes to IDLE.
  - No mem request is issued in the branch cycle.
- Further branches while in DISCARD: only fetch_pc is updated; the FSM stays in DISCARD.
- Address arithmetic: PC increment is modulo 2^XLEN (wraps at 0xFFFF_FFFC to 0).
- Pointers: read/write pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.
- Reset during WAIT: the FSM returns to IDLE. An inst_done that arrives afterwards in IDLE is ignored, and mem_ctrl must tolerate this.
- inst_done while in IDLE is always ignored.

Optional Feature:
- Macro: IF_ICACHE_EN.
- With the macro:
  - Direct-mapped cache of ICACHE_LINES word entries: valid bit, tag, data. Index = fetch_pc[log2(ICACHE_LINES)+1:2].
  - In IDLE with queue space, a hit enqueues the word that cycle, advances fetch_pc by 4 and issues no mem request (1 instruction/cycle).
  - A miss follows the normal path. The fill is written on inst_done in WAIT only; data dropped in DISCARD is never written.
  - Reset clears all valid bits.
- Without the macro: no cache storage and behaviour exactly as above.

Decomposition:
- Shared package/header (tmp.v style defines): XLEN default, RESET_PC, and the FSM state encodings IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2.
- One natural sub-module: if_inst_fifo (parametrised sync FIFO with push/pop/flush and count).
- The icache stays inline under the macro.

Test Plan:
- Reset, mem_ctrl returns inst_done 3 cycles after each request, id_ready_in = 1 -> requests to 0x0, 0x4, 0x8; decode sees pc_out 0x0, 0x4, 0x8 in order, each with the matching instruction.
- id_ready_in = 0, QUEUE_DEPTH = 4 -> exactly 4 words enqueued, queue_full_out = 1, no fifth request; a single pop -> exactly one new request.
- Branch_enable with target 0x100 while a request to 0x8 is in flight -> the 0x8 data is dropped, the queue is empty, the next request goes to 0x100, and the first instruction delivered has pc_out 0x100.
- Branch in the same cycle as inst_done and a pop -> no enqueue, queue cleared, FSM in IDLE, next request goes to the target.
- fetch_pc = 0xFFFF_FFFC, fetch completes -> next request goes to 0x0.
- IF_ICACHE_EN: run 0x0–0xC, branch back to 0x0 -> the second pass issues no mem requests and delivers 1 instruction/cycle.
